// File: rtl/lab4_decrypt_if.sv
// lab4_decrypt_if: link-side and result-side signals of the LFSR decryptor
interface lab4_decrypt_if #(parameter int lfsr_bitwidth = 5);
  logic start;
  logic [lfsr_bitwidth-1:0] taps;
  logic [lfsr_bitwidth-1:0] seed;
  logic [3:0] preambleLength;
  logic [7:0] encryptByte;
  logic validIn;
  logic inReady;
  logic [7:0] plainByte;
  logic validOut;
  logic busy;
  logic packetDone;
  logic preambleErr;
  modport master (
    output start, taps, seed, preambleLength, encryptByte, validIn,
    input inReady, plainByte, validOut, busy, packetDone, preambleErr
  );
  modport slave (
    input start, taps, seed, preambleLength, encryptByte, validIn,
    output inReady, plainByte, validOut, busy, packetDone, preambleErr
  );
endinterface

// File: rtl/lab4_decrypt_dp.sv
// lab4_decrypt_dp: FIFO-fed LFSR packet decryptor (32-byte packets); define LAB4_PREAMBLE_CHECK_EN to flag bad preamble bytes
module lab4_decrypt_dp #(
  parameter int DEPTH = 16,
  parameter int lfsr_bitwidth = 5
) (
  input logic clk,
  input logic rst,
  lab4_decrypt_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, PREAMBLE, PAYLOAD} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, consume, is_payload, last;
  logic [lfsr_bitwidth-1:0] lfsr, taps_q, seed_q;
  logic [3:0] len_q;
  logic [5:0] byte_count;
  logic [7:0] dec;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? LOAD : IDLE;
      LOAD: state_n = (len_q == 4'd0) ? PAYLOAD : PREAMBLE;
      default: state_n = !consume ? state :
                         last ? IDLE :
                         (byte_count + 6'd1 >= {2'b00, len_q}) ? PAYLOAD : PREAMBLE;
    endcase
  end
  // A pop frees a slot in the same cycle, so a full FIFO still accepts while draining
  always_comb begin
    bus.busy = state != IDLE;
    consume = (state == PREAMBLE || state == PAYLOAD) && !empty;
    bus.inReady = !full || consume;
    push = bus.validIn && bus.inReady;
    dec = mem[rd_ptr[AW-1:0]] ^ {{(8-lfsr_bitwidth){1'b0}}, lfsr};
    is_payload = byte_count >= {2'b00, len_q};
    last = byte_count == 6'd31;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.encryptByte;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lfsr <= '0;
      taps_q <= '0;
      seed_q <= '0;
      len_q <= '0;
      byte_count <= '0;
      bus.validOut <= 1'b0;
      bus.packetDone <= 1'b0;
      bus.plainByte <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (consume) rd_ptr <= rd_ptr + 1'b1;
      if (state == IDLE && bus.start) begin
        taps_q <= bus.taps;
        seed_q <= bus.seed;
        len_q <= bus.preambleLength;
      end
      if (state == LOAD) begin
        lfsr <= seed_q;
        byte_count <= '0;
      end else if (consume) begin
        lfsr <= {lfsr[lfsr_bitwidth-2:0], ^(lfsr & taps_q)};
        byte_count <= byte_count + 6'd1;
      end
      bus.validOut <= consume && is_payload;
      bus.packetDone <= consume && last;
      if (consume && is_payload) bus.plainByte <= dec;
    end
  end
`ifdef LAB4_PREAMBLE_CHECK_EN
  logic err;
  always_ff @(posedge clk)
    err <= rst || (state == IDLE && bus.start) ? 1'b0 :
           (consume && !is_payload && dec != 8'h7E) ? 1'b1 : err;
  assign bus.preambleErr = err;
`else
  assign bus.preambleErr = 1'b0;
`endif
endmodule

// File: tb/tb_lab4_decrypt_dp.sv
// tb_lab4_decrypt_dp: directed packets encrypted by a reference LFSR encryptor, checked against the payload text
module tb_lab4_decrypt_dp;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int last_done = 0;
  logic [7:0] out_q [$];
  logic [7:0] pay [$];
  logic [7:0] enc [32];
  lab4_decrypt_if bus ();
  lab4_decrypt_dp dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.validOut) out_q.push_back(bus.plainByte);
    if (bus.packetDone) begin
      done_cnt++;
      if (bus.validOut) last_done = out_q.size();
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic void gen(input logic [4:0] t, input logic [4:0] s, input int len, input int corrupt);
    logic [4:0] l = s;
    logic [7:0] p;
    pay.delete();
    for (int i = 0; i < 32; i++) begin
      p = (i < len) ? 8'h7E : 8'h41 + 8'(i - len);
      if (i >= len) pay.push_back(p);
      enc[i] = p ^ {3'b000, l} ^ ((i == corrupt) ? 8'h01 : 8'h00);
      l = {l[3:0], ^(l & t)};
    end
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.validIn = 1'b0;
    bus.encryptByte = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic start_pkt(input logic [4:0] t, input logic [4:0] s, input logic [3:0] len);
    bus.taps = t;
    bus.seed = s;
    bus.preambleLength = len;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic send(input int first, input int last_i, input int gap);
    int t;
    for (int i = first; i <= last_i; i++) begin
      bus.encryptByte = enc[i];
      bus.validIn = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.inReady && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("send_timeout", 32'(t), 32'd0);
      @(posedge clk);
      #1 bus.validIn = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic wait_done(input string tag, input int target);
    int t = 0;
    while (done_cnt < target && t < 400) begin
      @(posedge clk);
      #1 t++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask
  task automatic check_packet(input string tag, input int base, input int n);
    check({tag, "_count"}, 32'(out_q.size() - base), 32'(n));
    for (int k = 0; k < n && base + k < out_q.size(); k++)
      check({tag, "_byte"}, 32'(out_q[base+k]), 32'(pay[k]));
    check({tag, "_done_at"}, 32'(last_done - base), 32'(n));
  endtask
  initial begin
    int base, acc, d0;
    bus.taps = '0;
    bus.seed = '0;
    bus.preambleLength = '0;
    do_reset();
    @(negedge clk);
    check("rst_inReady", 32'(bus.inReady), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_validOut", 32'(bus.validOut), 32'd0);
    check("rst_packetDone", 32'(bus.packetDone), 32'd0);
    check("rst_plainByte", 32'(bus.plainByte), 32'h00);
    check("rst_preambleErr", 32'(bus.preambleErr), 32'd0);
    @(posedge clk);
    #1;
    // preamble of 7, back-to-back bytes
    gen(5'h1E, 5'h01, 7, -1);
    base = out_q.size();
    start_pkt(5'h1E, 5'h01, 4'd7);
    @(negedge clk);
    check("s1_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 send(0, 31, 0);
    wait_done("s1_done", 1);
    check_packet("s1", base, 25);
    check("s1_err", 32'(bus.preambleErr), 32'd0);
    check("s1_idle", 32'(bus.busy), 32'd0);
    // no preamble: first key byte is the seed
    gen(5'h1E, 5'h01, 0, -1);
    base = out_q.size();
    start_pkt(5'h1E, 5'h01, 4'd0);
    send(0, 31, 0);
    wait_done("s2_done", 2);
    check_packet("s2", base, 32);
    check("s2_first", 32'(out_q[base]), 32'(enc[0] ^ 8'h01));
    check("s2_first_A", 32'(out_q[base]), 32'h41);
    check("s2_hold", 32'(bus.plainByte), 32'(pay[31]));
    // bytes queued while idle drain first
    gen(5'h14, 5'h13, 0, -1);
    acc = 0;
    bus.validIn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.encryptByte = enc[acc];
      @(negedge clk);
      if (bus.inReady) acc++;
      @(posedge clk);
      #1;
    end
    bus.validIn = 1'b0;
    check("s3_accepted", 32'(acc), 32'd16);
    @(negedge clk);
    check("s3_full", 32'(bus.inReady), 32'd0);
    @(posedge clk);
    #1 base = out_q.size();
    start_pkt(5'h14, 5'h13, 4'd0);
    send(16, 31, 0);
    wait_done("s3_done", 3);
    check_packet("s3", base, 32);
    // gapped input gives the same bytes as back-to-back
    gen(5'h1E, 5'h01, 7, -1);
    base = out_q.size();
    start_pkt(5'h1E, 5'h01, 4'd7);
    send(0, 31, 1);
    wait_done("s4_done", 4);
    check_packet("s4", base, 25);
    // reset mid-packet, then a fresh packet with a new seed
    start_pkt(5'h1E, 5'h01, 4'd7);
    send(0, 9, 0);
    repeat (3) @(posedge clk);
    #1 d0 = done_cnt;
    do_reset();
    base = out_q.size();
    repeat (40) @(posedge clk);
    #1;
    check("s5_no_done", 32'(done_cnt), 32'(d0));
    check("s5_no_valid", 32'(out_q.size() - base), 32'd0);
    check("s5_inReady", 32'(bus.inReady), 32'd1);
    gen(5'h12, 5'h0B, 3, -1);
    start_pkt(5'h12, 5'h0B, 4'd3);
    send(0, 31, 0);
    wait_done("s5_done", d0 + 1);
    check_packet("s5", base, 29);
    // corrupted preamble byte 3
    gen(5'h1E, 5'h01, 7, 3);
    base = out_q.size();
    d0 = done_cnt;
    start_pkt(5'h1E, 5'h01, 4'd7);
    send(0, 2, 0);
    repeat (3) @(posedge clk);
    #1 check("s6_err_before", 32'(bus.preambleErr), 32'd0);
    send(3, 31, 0);
    wait_done("s6_done", d0 + 1);
    check_packet("s6", base, 25);
`ifdef LAB4_PREAMBLE_CHECK_EN
    check("s6_err_set", 32'(bus.preambleErr), 32'd1);
    start_pkt(5'h1E, 5'h01, 4'd7);
    @(negedge clk);
    check("s6_err_cleared", 32'(bus.preambleErr), 32'd0);
`else
    check("s6_err_tied", 32'(bus.preambleErr), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
